// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester arbiter in front of a single-port RAM.
// Requesters are instruction fetch (if), load-store (ls) and the RISK unit
// (rk). Grants are combinational; read data returns through a two-entry
// requester-id pipeline so that rvalid rises exactly two cycles after gnt.
// RISK bursts lock the RAM for up to MAX_BURST consecutive beats.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration
// in IDLE. Without it, fixed priority ls > if > rk is used.
module mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  // load-store
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_wsize,
  input  logic [31:0]       ls_wdata,
  // RISK unit
  input  logic              rk_req,
  input  logic [ADDR_W-1:0] rk_addr,
  input  logic              rk_last,
  // grants and read returns
  output logic              if_gnt,
  output logic              ls_gnt,
  output logic              rk_gnt,
  output logic              if_rvalid,
  output logic              ls_rvalid,
  output logic              rk_rvalid,
  output logic [31:0]       rdata,
  // RAM command port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_wsize,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  // Requester ids; SRC_NONE doubles as "no grant" and "empty pipe slot".
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IF,
    SRC_LS,
    SRC_RK
  } src_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  src_t              sel;
  logic              sel_is_read;
  logic [ADDR_W-1:0] last_addr;
  src_t              rd_s1, rd_s2;

`ifdef MEM_ARBITER_RR_EN
  // Round-robin pointer: the requester that gets first look next time.
  src_t rr_ptr;

  // Pick the first active requester starting from the pointer.
  function automatic src_t rr_pick(input src_t ptr, input logic r_if,
                                   input logic r_ls, input logic r_rk);
    src_t pick;
    pick = SRC_NONE;
    case (ptr)
      SRC_LS: begin
        if (r_ls)      pick = SRC_LS;
        else if (r_rk) pick = SRC_RK;
        else if (r_if) pick = SRC_IF;
      end
      SRC_RK: begin
        if (r_rk)      pick = SRC_RK;
        else if (r_if) pick = SRC_IF;
        else if (r_ls) pick = SRC_LS;
      end
      default: begin
        if (r_if)      pick = SRC_IF;
        else if (r_ls) pick = SRC_LS;
        else if (r_rk) pick = SRC_RK;
      end
    endcase
    return pick;
  endfunction
`endif

  // Select the requester that owns the RAM this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel = SRC_NONE;
    if (!resetn) begin
      sel = SRC_NONE;
    end else if (state == BURST && rk_req) begin
      // An open burst owns the RAM outright while rk keeps requesting.
      sel = SRC_RK;
    end else begin
`ifdef MEM_ARBITER_RR_EN
      sel = rr_pick(rr_ptr, if_req, ls_req, rk_req);
`else
      if (ls_req)      sel = SRC_LS;
      else if (if_req) sel = SRC_IF;
      else if (rk_req) sel = SRC_RK;
`endif
    end
  end

  assign if_gnt = (sel == SRC_IF);
  assign ls_gnt = (sel == SRC_LS);
  assign rk_gnt = (sel == SRC_RK);

  // Only ls can write; every other grant is a read that returns data.
  assign sel_is_read = (sel != SRC_NONE) && !(sel == SRC_LS && ls_wsize != 2'b00);

  // Drive the RAM command from the granted requester; idle cycles keep the
  // last address and issue no write.
  always_comb begin
    mem_addr  = last_addr;
    mem_wdata = '0;
    mem_wsize = 2'b00;
    case (sel)
      SRC_IF: mem_addr = if_addr;
      SRC_LS: begin
        mem_addr  = ls_addr;
        mem_wsize = ls_wsize;
        mem_wdata = (ls_wsize != 2'b00) ? ls_wdata : '0;
      end
      SRC_RK: mem_addr = rk_addr;
      default: ;
    endcase
  end

  // Burst tracking: open on a non-final rk beat in IDLE, close on the last
  // beat, on the beat that reaches MAX_BURST, or when rk drops its request.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (rk_gnt && !rk_last && MAX_BURST > 1) begin
          state_nxt    = BURST;
          beat_cnt_nxt = CNT_W'(1);
        end
      end
      BURST: begin
        if (!rk_gnt) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else if (rk_last || (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // State, address hold, read-id pipeline and read-data register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; every register, including the read
    // pipeline and rdata, is cleared so in-flight reads are dropped.
    if (!resetn) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      last_addr <= '0;
      rd_s1     <= SRC_NONE;
      rd_s2     <= SRC_NONE;
      rdata     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      last_addr <= mem_addr;
      rd_s1     <= sel_is_read ? sel : SRC_NONE;
      rd_s2     <= rd_s1;
      rdata     <= mem_rdata;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Advance the pointer past whichever requester was just served.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= SRC_IF;
    end else begin
      case (sel)
        SRC_IF:  rr_ptr <= SRC_LS;
        SRC_LS:  rr_ptr <= SRC_RK;
        SRC_RK:  rr_ptr <= SRC_IF;
        default: rr_ptr <= rr_ptr;
      endcase
    end
  end
`endif

  assign if_rvalid = (rd_s2 == SRC_IF);
  assign ls_rvalid = (rd_s2 == SRC_LS);
  assign rk_rvalid = (rd_s2 == SRC_RK);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default build: fixed
// priority; the round-robin sequence is exercised when MEM_ARBITER_RR_EN
// is defined). Inputs change just after the falling edge, outputs are
// checked 1 time unit later, away from the rising edge.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        if_req;
  logic [13:0] if_addr;
  logic        ls_req;
  logic [13:0] ls_addr;
  logic [1:0]  ls_wsize;
  logic [31:0] ls_wdata;
  logic        rk_req;
  logic [13:0] rk_addr;
  logic        rk_last;
  logic        if_gnt, ls_gnt, rk_gnt;
  logic        if_rvalid, ls_rvalid, rk_rvalid;
  logic [31:0] rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wsize;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(14), .MAX_BURST(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_wsize  (ls_wsize),
    .ls_wdata  (ls_wdata),
    .rk_req    (rk_req),
    .rk_addr   (rk_addr),
    .rk_last   (rk_last),
    .if_gnt    (if_gnt),
    .ls_gnt    (ls_gnt),
    .rk_gnt    (rk_gnt),
    .if_rvalid (if_rvalid),
    .ls_rvalid (ls_rvalid),
    .rk_rvalid (rk_rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wsize (mem_wsize),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: word 0x0040 holds 0x13, every other address a tagged value.
  function automatic logic [31:0] ram_word(input logic [13:0] a);
    if (a == 14'h0040) return 32'h0000_0013;
    return 32'hA5A5_0000 | {18'd0, a};
  endfunction

  // Synchronous-read RAM: data for the address of one cycle appears the next.
  always @(posedge clk) mem_rdata <= ram_word(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_addr  = '0;
    ls_wsize = 2'b00;
    ls_wdata = '0;
    rk_req   = 1'b0;
    rk_addr  = '0;
    rk_last  = 1'b0;
  endtask

  logic [2:0] exp_g;
  int         beat;
  int         n_if_rv, n_rk_rv;
  logic       if_seen;

  initial begin
    clear_inputs();
    resetn = 1'b0;
    if_req = 1'b1;                        // request during reset must not be granted

    // ---- reset ----
    cyc(); #1;
    check("rst_gnt", {if_gnt, ls_gnt, rk_gnt}, 3'b000);
    check("rst_wsize", mem_wsize, 2'b00);
    cyc(); #1;
    check("rst_rvalid", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 14'h0);
    check("rst_gnt2", {if_gnt, ls_gnt, rk_gnt}, 3'b000);
    cyc();
    resetn = 1'b1;
    if_req = 1'b0;
    #1;
    check("rel_gnt", {if_gnt, ls_gnt, rk_gnt}, 3'b000);

    // ---- single if read of 0x0040 ----
    cyc();
    if_req = 1'b1; if_addr = 14'h0040;
    #1;
    check("if_gnt", {if_gnt, ls_gnt, rk_gnt}, 3'b100);
    check("if_mem_addr", mem_addr, 14'h0040);
    check("if_mem_wsize", mem_wsize, 2'b00);
    cyc();
    if_req = 1'b0;
    #1;
    check("if_rvalid_early", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);
    check("idle_addr_hold", mem_addr, 14'h0040);
    cyc(); #1;
    check("if_rvalid", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b100);
    check("if_rdata", rdata, 32'h0000_0013);
    cyc(); #1;
    check("if_rvalid_after", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);

    // ---- if and ls read together: ls first ----
    cyc();
    if_req = 1'b1; if_addr = 14'h0080;
    ls_req = 1'b1; ls_addr = 14'h0100; ls_wsize = 2'b00;
    #1;
    check("pri_gnt0", {if_gnt, ls_gnt, rk_gnt}, 3'b010);
    check("pri_addr0", mem_addr, 14'h0100);
    cyc();
    ls_req = 1'b0;
    #1;
    check("pri_gnt1", {if_gnt, ls_gnt, rk_gnt}, 3'b100);
    check("pri_addr1", mem_addr, 14'h0080);
    cyc();
    if_req = 1'b0;
    #1;
    check("pri_rv0", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b010);
    check("pri_rdata0", rdata, ram_word(14'h0100));
    cyc(); #1;
    check("pri_rv1", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b100);
    check("pri_rdata1", rdata, ram_word(14'h0080));

    // ---- ls half-word write ----
    cyc();
    ls_req = 1'b1; ls_addr = 14'h0200; ls_wsize = 2'b10; ls_wdata = 32'h0000_BEEF;
    #1;
    check("wr_gnt", {if_gnt, ls_gnt, rk_gnt}, 3'b010);
    check("wr_wsize", mem_wsize, 2'b10);
    check("wr_wdata", mem_wdata, 32'h0000_BEEF);
    check("wr_addr", mem_addr, 14'h0200);
    cyc();
    ls_req = 1'b0;
    #1;
    check("wr_wsize_after", mem_wsize, 2'b00);
    check("wr_addr_hold", mem_addr, 14'h0200);
    cyc(); #1;
    check("wr_no_rv0", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);
    cyc(); #1;
    check("wr_no_rv1", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);

    // ---- 20-beat rk burst against a waiting if: 16 rk, 1 if, 4 rk ----
    beat    = 0;
    n_if_rv = 0;
    n_rk_rv = 0;
    if_seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cyc();
      if (c == 1) begin
        if_req  = 1'b1;
        if_addr = 14'h0300;
      end
      if (if_seen) if_req = 1'b0;
      rk_req  = (beat < 20);
      rk_addr = 14'h1000 + 14'(beat * 4);
      rk_last = (beat == 19);
      #1;
      if (c < 16 || (c >= 17 && c <= 20)) exp_g = 3'b001;
      else if (c == 16)                   exp_g = 3'b100;
      else                                exp_g = 3'b000;
      check($sformatf("burst_gnt_c%0d", c), {if_gnt, ls_gnt, rk_gnt}, exp_g);
      if (c == 18) begin
        check("burst_if_rv", if_rvalid, 1'b1);
        check("burst_if_rdata", rdata, ram_word(14'h0300));
      end
      if (rk_gnt) beat++;
      if (if_gnt) if_seen = 1'b1;
      n_if_rv += int'(if_rvalid);
      n_rk_rv += int'(rk_rvalid);
    end
    check("burst_rk_rv_count", n_rk_rv, 20);
    check("burst_if_rv_count", n_if_rv, 1);
    clear_inputs();

    // ---- ls write held off by a 3-beat burst, then rk_last/rk_req release ----
    cyc();
    rk_req = 1'b1; rk_addr = 14'h2000; rk_last = 1'b0;
    #1;
    check("hold_g0", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    rk_addr = 14'h2004;
    ls_req = 1'b1; ls_addr = 14'h0204; ls_wsize = 2'b11; ls_wdata = 32'hCAFE_F00D;
    #1;
    check("hold_g1", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    check("hold_wsize1", mem_wsize, 2'b00);
    cyc();
    rk_addr = 14'h2008; rk_last = 1'b1;
    #1;
    check("hold_g2", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    rk_addr = 14'h200C; rk_last = 1'b0;   // new burst waiting; must be IDLE now
    #1;
    check("last_release_g", {if_gnt, ls_gnt, rk_gnt}, 3'b010);
    check("last_release_wsize", mem_wsize, 2'b11);
    check("last_release_wdata", mem_wdata, 32'hCAFE_F00D);
    cyc();
    ls_req = 1'b0; ls_wsize = 2'b00;
    #1;
    check("reburst_g", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    rk_req = 1'b0;
    #1;
    check("gap_g", {if_gnt, ls_gnt, rk_gnt}, 3'b000);
    cyc();
    rk_req = 1'b1; rk_addr = 14'h2010;
    ls_req = 1'b1; ls_addr = 14'h0208; ls_wsize = 2'b00;
    #1;
    check("gap_release_g", {if_gnt, ls_gnt, rk_gnt}, 3'b010);
    cyc();
    ls_req = 1'b0;
    #1;
    check("gap_rk_g", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    rk_req = 1'b0;
    #1;
    check("gap_ls_rv", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b010);
    check("gap_ls_rdata", rdata, ram_word(14'h0208));

    // ---- reset in the middle of a burst with reads in flight ----
    cyc();
    rk_req = 1'b1; rk_addr = 14'h2100; rk_last = 1'b0;
    #1;
    check("mid_rst_g0", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    rk_addr = 14'h2104;
    #1;
    check("mid_rst_g1", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    resetn = 1'b0;
    #1;
    check("mid_rst_gnt", {if_gnt, ls_gnt, rk_gnt}, 3'b000);
    check("mid_rst_wsize", mem_wsize, 2'b00);
    cyc();
    resetn = 1'b1;
    rk_addr = 14'h2108;
    ls_req = 1'b1; ls_addr = 14'h020C; ls_wsize = 2'b00;
    #1;
    check("post_rst_idle_g", {if_gnt, ls_gnt, rk_gnt}, 3'b010);
    check("post_rst_rv0", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);
    cyc();
    ls_req = 1'b0;
    #1;
    check("post_rst_rv1", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b000);
    check("post_rst_rk_g", {if_gnt, ls_gnt, rk_gnt}, 3'b001);
    cyc();
    rk_req = 1'b0;
    #1;
    check("post_rst_ls_rv", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b010);
    check("post_rst_ls_rdata", rdata, ram_word(14'h020C));
    cyc(); #1;
    check("post_rst_rk_rv", {if_rvalid, ls_rvalid, rk_rvalid}, 3'b001);
    check("post_rst_rk_rdata", rdata, ram_word(14'h2108));
    clear_inputs();

`ifdef MEM_ARBITER_RR_EN
    // ---- round robin: all three requesting, single-beat rk ----
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    if_req = 1'b1; if_addr = 14'h0010;
    ls_req = 1'b1; ls_addr = 14'h0020; ls_wsize = 2'b00;
    rk_req = 1'b1; rk_addr = 14'h0030; rk_last = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        cyc(); #1;
      end
      case (c % 3)
        0:       exp_g = 3'b100;
        1:       exp_g = 3'b010;
        default: exp_g = 3'b001;
      endcase
      check($sformatf("rr_gnt_c%0d", c), {if_gnt, ls_gnt, rk_gnt}, exp_g);
    end
    clear_inputs();
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, byte-address width of every address port.
REQ-002 Parameter MAX_BURST, default 16, maximum consecutive RISK beats granted before a forced release.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 if_req / if_addr  input  1 / ADDR_W  instruction-fetch read request and word-aligned address.
REQ-006 ls_req / ls_addr / ls_wsize / ls_wdata  input  1 / ADDR_W / 2 / 32  load-store request; wsize 00=read, 01=byte, 10=half, 11=word write.
REQ-007 rk_req / rk_addr / rk_last  input  1 / ADDR_W / 1  RISK unit read request; rk_last marks the final beat of a burst.
REQ-008 if_gnt, ls_gnt, rk_gnt  output  1 each  request accepted this cycle; at most one high.
REQ-009 if_rvalid, ls_rvalid, rk_rvalid  output  1 each  rdata valid for that requester; at most one high.
REQ-010 rdata  output  32  read data, registered copy of mem_rdata.
REQ-011 mem_addr / mem_wdata / mem_wsize  output  ADDR_W / 32 / 2  single-port RAM command, combinational from the granted requester.
REQ-012 mem_rdata  input  32  RAM read data, valid one cycle after the address.

Function
REQ-013 Grant is combinational: a request is granted in the cycle it is high if the arbiter selects it; the requester holds req/addr/wdata stable until gnt.
REQ-014 Fixed priority (macro absent): ls > if > rk.
REQ-015 A granted read gives mem_wsize=00 and mem_addr=requester address; the matching rvalid rises exactly 2 cycles after gnt, with rdata valid in that cycle.
REQ-016 A granted ls write drives mem_wsize=ls_wsize and mem_wdata=ls_wdata for that cycle only; no ls_rvalid follows.
REQ-017 In any cycle with no grant, mem_wsize SHALL be 00 and mem_addr SHALL hold its last value.
REQ-018 States: IDLE, BURST. IDLE->BURST when rk is granted with rk_last=0; beat counter loads 1.
REQ-019 In BURST, rk has absolute priority; each granted beat increments the counter; if and ls are held off.
REQ-020 BURST->IDLE on a granted beat with rk_last=1, on a granted beat that brings the counter to MAX_BURST, or when rk_req is low for one cycle; no grant is lost in the transition.
REQ-021 Back-to-back grants every cycle are supported; read pipeline depth is 2 entries of requester id.
REQ-022 Simultaneous ls write and pending rk read in BURST: the rk read is granted and ls waits.

Reset
REQ-023 While resetn=0 at a clock edge: state=IDLE, beat counter=0, round-robin pointer=if, all rvalid=0, rdata=0, mem_addr=0; gnt and mem_wsize are 0 during reset.
REQ-024 Reset during BURST or with reads in flight discards them; no rvalid is asserted in the cycles after reset release.

Configuration
REQ-025 Macro MEM_ARBITER_RR_EN defined: in IDLE, round-robin among if, ls, rk; pointer advances to the requester after the one granted; burst rules unchanged.
REQ-026 Macro MEM_ARBITER_RR_EN undefined: fixed priority per REQ-014; no pointer register is built.

Verification
REQ-027 if_req only, if_addr=0x0040, mem_rdata=0x00000013 -> if_gnt same cycle, if_rvalid and rdata=0x00000013 two cycles later.
REQ-028 if_req and ls_req (read, 0x0100) in the same cycle, fixed priority -> ls_gnt first, if_gnt next cycle, rvalids in the same order.
REQ-029 ls write 0x0200, wsize=10, wdata=0xBEEF -> mem_wsize=10 for one cycle, then 00; no ls_rvalid.
REQ-030 rk burst of 20 beats with rk_last on beat 20, if_req held high, MAX_BURST=16 -> 16 rk grants, one if grant, 4 rk grants.
REQ-031 resetn low for one cycle during a 3-beat rk burst -> no rvalid for 2 cycles after release, state IDLE.
REQ-032 With MEM_ARBITER_RR_EN, all three requesting continuously with rk_last=1 -> grant order repeats if, ls, rk.
